imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Writer side of the instruction-memory interface: receives a program image as a byte stream
//  (valid/ready) and writes it word by word into instruction memory. Holds the processor core in
//  reset (cpu_resetn low) until the image is loaded. Sits between a host byte source (UART RX/JTAG)
//  and the instruction memory write port.
// PARAMETERS
//  ADDR_WIDTH  10            word-address bits of instruction memory; MAX_WORDS = 2**ADDR_WIDTH (<=16)
//  BASE_ADDR   32'h00000000  byte address of the first word written (word aligned)
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  resetn      in   1   asynchronous active-low reset
//  rx_data     in   8   incoming byte
//  rx_valid    in   1   rx_data valid
//  rx_ready    out  1   loader can accept a byte; transfer when rx_valid && rx_ready
//  mem_we      out  1   one-cycle write strobe to instruction memory
//  mem_addr    out  32  byte address of write (BASE_ADDR + 4*word_index)
//  mem_wdata   out  32  write data word
//  busy        out  1   frame in progress (sync byte seen, not yet DONE/ERROR)
//  done        out  1   image loaded successfully (sticky)
//  error       out  1   frame rejected (sticky)
//  cpu_resetn  out  1   active-low core reset; low until done
// BEHAVIOUR
//  - Reset (async, resetn=0): state=IDLE; rx_ready, mem_we, busy, done, error, cpu_resetn = 0;
//    mem_addr = BASE_ADDR, mem_wdata = 0; counters cleared. All outputs registered.
//  - Frame: SYNC 0xA5 | N[7:0] | N[15:8] | 4*N data bytes, each word little-endian | [CHECKSUM].
//  - States: IDLE -> LEN_LO -> LEN_HI -> DATA -> (CHECK) -> DONE; any -> ERROR as below.
//    IDLE: rx_ready=1; bytes != 0xA5 discarded; 0xA5 -> LEN_LO, busy=1.
//    LEN_LO: capture N low byte. LEN_HI: capture N high byte, then:
//      N > MAX_WORDS -> ERROR; N == 0 -> DONE (or CHECK if macro on); else -> DATA.
//    DATA: byte k (k=0..3) lands in word[8k+7:8k]; on edge accepting byte 3 of word i:
//      mem_we<=1 for exactly one cycle, mem_addr<=BASE_ADDR+4*i, mem_wdata<=assembled word.
//      After word N-1 -> DONE (or CHECK). rx_ready stays 1 in DATA; no back-pressure; one byte/cycle max.
//    DONE: rx_ready=0, busy=0, done=1, cpu_resetn=1; done/cpu_resetn rise the cycle after the last
//      mem_we pulse (never coincident with a write). Sticky until resetn.
//    ERROR: rx_ready=0, busy=0, error=1, cpu_resetn=0. Sticky until resetn.
//  - rx_valid gaps (bubbles) anywhere: state and counters hold; no effect on result.
//  - rx_valid while rx_ready=0: ignored, no state change.
//  - Word index never wraps: N<=MAX_WORDS guaranteed by LEN_HI check; N==MAX_WORDS legal.
//  - Reset mid-frame: frame abandoned; a partially assembled word is never written; words already
//    written stay in memory; loader restarts at IDLE expecting 0xA5.
//  - mem_addr/mem_wdata hold last written values between strobes.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: after the last data byte (or after LEN_HI when N==0) state CHECK
//    accepts one byte; equal to 8-bit sum mod 256 of all data bytes -> DONE, else -> ERROR.
//    Writes already issued are not undone; cpu_resetn stays 0 on ERROR.
//  LOADER_CHECKSUM_EN undefined: no CHECK state, no checksum byte; DATA -> DONE directly.
// TESTING
//  1. A5 02 00 13 00 00 00 93 00 10 00 -> mem_we@0x0=0x00000013, mem_we@0x4=0x00100093; done=1,
//     cpu_resetn=1 one cycle after 2nd strobe; error=0.
//  2. 00 FF 5A then frame of test 1 -> leading bytes ignored, identical writes and done.
//  3. A5 00 00 -> no mem_we; done=1 (macro off). Macro on: requires trailing 00 before done.
//  4. ADDR_WIDTH=10, A5 01 04 (N=1025) -> error=1, no mem_we, cpu_resetn=0, rx_ready=0.
//  5. Test 1 with random 0-5 cycle rx_valid gaps, then resetn pulsed after 2 data bytes of a new
//     frame -> no write of partial word; fresh test-1 frame again loads from BASE_ADDR.
//  6. Macro on: test-1 frame + B6 -> done=1; + B7 -> error=1, both writes issued, cpu_resetn=0.

Source files
------------

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//
// Writer side of the instruction-memory interface. Receives a program image as
// a valid/ready byte stream from a host source (UART RX, JTAG) and writes it
// word by word into instruction memory. The processor core is held in reset
// (cpu_resetn low) until the whole image has been loaded.
//
// Frame format:
//   0xA5 | N[7:0] | N[15:8] | 4*N data bytes (little-endian words) | [CHECKSUM]
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   -> one trailing byte must equal the 8-bit sum of all data bytes.
//                A match ends in DONE; a mismatch ends in ERROR.
//   undefined -> no checksum byte; the last data word leads directly to DONE.
//
// Parameters:
//   ADDR_WIDTH  word-address bits of instruction memory (MAX_WORDS = 2**ADDR_WIDTH, <= 16)
//   BASE_ADDR   byte address of the first word written (word aligned)
//
// Ports:
//   clk         in   1   system clock, rising edge
//   resetn      in   1   asynchronous active-low reset
//   rx_data     in   8   incoming byte
//   rx_valid    in   1   rx_data valid
//   rx_ready    out  1   loader accepts a byte (transfer on rx_valid && rx_ready)
//   mem_we      out  1   one-cycle instruction-memory write strobe
//   mem_addr    out  32  byte address of the write
//   mem_wdata   out  32  write data word
//   busy        out  1   frame in progress
//   done        out  1   image loaded (sticky)
//   error       out  1   frame rejected (sticky)
//   cpu_resetn  out  1   active-low core reset, released once done
// -----------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_resetn
);

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK  = 3'd4,
`endif
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_e;

    // State entered once the image payload has been fully received.
`ifdef LOADER_CHECKSUM_EN
    localparam state_e ST_AFTER_DATA = ST_CHECK;
`else
    localparam state_e ST_AFTER_DATA = ST_DONE;
`endif

    state_e        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [16:0]   word_idx_q, word_idx_d;   // one extra bit so N == MAX_WORDS never wraps
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [23:0]   asm_q, asm_d;             // low three bytes of the word being assembled
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    sum_q, sum_d;
`endif
    logic          rx_ready_q, rx_ready_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          cpu_resetn_q, cpu_resetn_d;
    logic          accept_s;

    assign accept_s = rx_valid && rx_ready_q;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        byte_cnt_d  = byte_cnt_q;
        asm_d       = asm_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s && (rx_data == SYNC_BYTE)) begin
                    state_d    = ST_LEN_LO;
                    word_idx_d = 17'd0;
                    byte_cnt_d = 2'd0;
                    asm_d      = 24'd0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = 8'd0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LEN_LO: begin
                if (accept_s) begin
                    len_d[7:0] = rx_data;
                    state_d    = ST_LEN_HI;
                end else begin
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_HI: begin
                if (accept_s) begin
                    len_d = {rx_data, len_q[7:0]};
                    if ({1'b0, len_d} > MAX_WORDS) begin
                        state_d = ST_ERROR;
                    end else if (len_d == 16'd0) begin
                        state_d = ST_AFTER_DATA;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_LEN_HI;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = sum_q + rx_data;
`endif
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Final byte of a word: the only place a write is issued.
                        mem_we_d    = 1'b1;
                        mem_addr_d  = BASE_ADDR + {13'd0, word_idx_q, 2'b00};
                        mem_wdata_d = {rx_data, asm_q};
                        word_idx_d  = word_idx_q + 17'd1;
                        if (word_idx_d == {1'b0, len_q}) begin
                            state_d = ST_AFTER_DATA;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        // Shift in from the top so byte k ends up at [8k+7:8k].
                        asm_d   = {rx_data, asm_q[23:8]};
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept_s) begin
                    if (rx_data == sum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end else begin
                    state_d = ST_CHECK;
                end
            end
`endif
            ST_DONE:  state_d = ST_DONE;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase

        // Handshake follows the next state so no byte is taken once a terminal state is reached.
        rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_LEN_LO) ||
                     (state_d == ST_LEN_HI) || (state_d == ST_DATA)
`ifdef LOADER_CHECKSUM_EN
                     || (state_d == ST_CHECK)
`endif
                     ;
        busy_d     = rx_ready_d && (state_d != ST_IDLE);
        // Status follows the current state, so done/cpu_resetn rise one cycle
        // after the final write strobe rather than together with it.
        done_d       = (state_q == ST_DONE);
        cpu_resetn_d = (state_q == ST_DONE);
        error_d      = (state_q == ST_ERROR);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            len_q        <= 16'd0;
            word_idx_q   <= 17'd0;
            byte_cnt_q   <= 2'd0;
            asm_q        <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= 8'd0;
`endif
            rx_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= BASE_ADDR;
            mem_wdata_q  <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_resetn_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
            rx_ready_q   <= rx_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_resetn_q <= cpu_resetn_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign cpu_resetn = cpu_resetn_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
//
// Self-checking bench for imem_boot_loader (ADDR_WIDTH=10, BASE_ADDR=0).
// Expected memory writes are queued as each word's final byte is driven and
// popped by a monitor whenever the loader strobes mem_we. Honours
// LOADER_CHECKSUM_EN by appending the checksum byte the loader expects.
// -----------------------------------------------------------------------------
module tb_imem_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk;
    logic        resetn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_resetn;

    int          n_checks;
    int          n_fail;
    logic [63:0] sb_q[$];              // {addr, data} of each expected write
    logic [31:0] img [0:1023];

    imem_boot_loader #(
        .ADDR_WIDTH (10),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cpu_resetn (cpu_resetn)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            logic [63:0] e;
            check_eq("sb_expected_write", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("mem_addr", mem_addr, e[63:32]);
                check_eq("mem_wdata", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic do_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        resetn   = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_rx_ready", 32'(rx_ready), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        check_eq("rst_cpu_resetn", 32'(cpu_resetn), 32'd0);
        check_eq("rst_mem_addr", mem_addr, BASE);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        sb_q.delete();
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Drive one byte after an optional random bubble; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int waited;
        repeat ($urandom_range(gap_max, 0)) @(posedge clk);
        #1;
        waited = 0;
        while (rx_ready !== 1'b1 && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check_eq("rx_ready_wait", 32'(rx_ready), 32'd1);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Send a complete frame of n words from img[], then check the final status.
    task automatic send_frame(input int n, input int gap_max, input logic [7:0] ck_delta,
                              input logic expect_ok);
        logic [15:0] nn;
        logic [7:0]  sum;
        logic [31:0] w;
        nn  = 16'(n);
        sum = 8'd0;
        send_byte(8'hA5, gap_max);
        check_eq("busy_after_sync", 32'(busy), 32'd1);
        send_byte(nn[7:0], gap_max);
        send_byte(nn[15:8], gap_max);
        if (n <= 1024) begin
            for (int i = 0; i < n; i++) begin
                w = img[i];
                for (int k = 0; k < 4; k++) begin
                    sum = sum + w[8*k +: 8];
                    if (k == 3) sb_q.push_back({BASE + 32'(4 * i), w});
                    send_byte(w[8*k +: 8], gap_max);
                end
            end
`ifdef LOADER_CHECKSUM_EN
            check_eq("done_before_ck", 32'(done), 32'd0);
            send_byte(sum + ck_delta, gap_max);
`else
            if (n > 0) check_eq("last_we", 32'(mem_we), 32'd1);
`endif
        end
        check_eq("done_not_with_we", 32'(done), 32'd0);
        check_eq("cpu_rst_not_with_we", 32'(cpu_resetn), 32'd0);
        @(posedge clk);
        #1;
        check_eq("final_done", 32'(done), 32'(expect_ok));
        check_eq("final_cpu_resetn", 32'(cpu_resetn), 32'(expect_ok));
        check_eq("final_error", 32'(error), 32'(!expect_ok));
        check_eq("final_busy", 32'(busy), 32'd0);
        check_eq("final_rx_ready", 32'(rx_ready), 32'd0);
        check_eq("final_mem_we", 32'(mem_we), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic load_test1_image();
        img[0] = 32'h0000_0013;
        img[1] = 32'h0010_0093;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #12;

        // Test 1: basic two-word image.
        do_reset();
        load_test1_image();
        send_frame(2, 0, 8'd0, 1'b1);
        check_eq("hold_mem_addr", mem_addr, 32'h0000_0004);
        check_eq("hold_mem_wdata", mem_wdata, 32'h0010_0093);

        // Test 2: leading junk bytes ignored.
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h5A, 0);
        check_eq("junk_busy", 32'(busy), 32'd0);
        send_frame(2, 0, 8'd0, 1'b1);

        // Test 3: empty image.
        do_reset();
        send_frame(0, 0, 8'd0, 1'b1);

        // Test 4: N = 1025 exceeds memory size.
        do_reset();
        send_frame(1025, 0, 8'd0, 1'b0);
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        check_eq("err_sticky", 32'(error), 32'd1);
        check_eq("err_busy", 32'(busy), 32'd0);
        check_eq("err_rx_ready", 32'(rx_ready), 32'd0);

        // Boundary: N == MAX_WORDS is legal and fills the whole memory.
        do_reset();
        for (int i = 0; i < 1024; i++) img[i] = {16'(i) ^ 16'h5A5A, 16'(i)};
        send_frame(1024, 0, 8'd0, 1'b1);
        check_eq("full_last_addr", mem_addr, BASE + 32'h0000_0FFC);

        // Test 5: random bubbles, then a frame abandoned by reset, then a fresh load.
        do_reset();
        load_test1_image();
        send_frame(2, 5, 8'd0, 1'b1);
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("abandon_no_we", 32'(mem_we), 32'd0);
        send_frame(2, 0, 8'd0, 1'b1);

`ifdef LOADER_CHECKSUM_EN
        // Test 6: bad checksum -> error after both writes issued.
        do_reset();
        load_test1_image();
        send_frame(2, 0, 8'd1, 1'b0);
        check_eq("badck_wdata", mem_wdata, 32'h0010_0093);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
